// File: rtl/code_lock_if.sv
// Keypad-side bundle for code_lock.
//   digit  : keypad symbol, sampled each edge while entering
//   start  : entry enable; low abandons the attempt and relocks
//   out    : unlock (registered)
//   buzzer : sticky alarm (registered)
//   count  : symbols entered in the current attempt (0-4)
//   cp     : expected passcode symbol for the current position
//   ci     : last sampled keypad symbol (registered)
interface code_lock_if;
  logic [3:0] digit;
  logic       start;
  logic       out;
  logic       buzzer;
  logic [2:0] count;
  logic [3:0] cp;
  logic [3:0] ci;

  modport master (
    output digit, start,
    input  out, buzzer, count, cp, ci
  );

  modport slave (
    input  digit, start,
    output out, buzzer, count, cp, ci
  );
endinterface

// File: rtl/code_lock.sv
// Four-symbol combination lock.
// A keypad symbol is sampled once per clock while entry is enabled and is compared
// position-by-position with CODE. A full correct sequence raises out; MAX_TRIES failed
// attempts latch buzzer until reset.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : code_lock_if slave (digit/start in; out/buzzer/count/cp/ci out)
module code_lock #(
  parameter logic [15:0] CODE      = 16'hABFD,
  parameter int unsigned MAX_TRIES = 3
) (
  input logic        clk,
  input logic        reset,
  code_lock_if.slave bus
);

  localparam logic [2:0] MaxTries = 3'(MAX_TRIES);

  typedef enum logic [1:0] {StIdle, StEnter, StOpen, StAlarm} state_e;

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic       err_q, err_d;
  logic [2:0] fails_q, fails_d;
  logic [3:0] ci_q, ci_d;
  logic       out_q, out_d;
  logic       buzzer_q, buzzer_d;
  logic [3:0] cp;
  logic       err_new;

  // Expected symbol for the current position; zero once all four are in.
  always_comb begin
    cp = 4'h0;
    unique case (count_q)
      3'd0:    cp = CODE[15:12];
      3'd1:    cp = CODE[11:8];
      3'd2:    cp = CODE[7:4];
      3'd3:    cp = CODE[3:0];
      default: cp = 4'h0;
    endcase
  end

  // Mismatch flag including the symbol being sampled at this edge.
  assign err_new = err_q | (bus.digit != cp);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    err_d    = err_q;
    fails_d  = fails_q;
    ci_d     = ci_q;
    out_d    = out_q;
    buzzer_d = buzzer_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StEnter;
          count_d = 3'd0;
          err_d   = 1'b0;
        end
      end
      StEnter: begin
        if (!bus.start) begin
          // Abandoning wins over a simultaneous 4th symbol; not a failure.
          state_d = StIdle;
          count_d = 3'd0;
          err_d   = 1'b0;
        end else begin
          ci_d    = bus.digit;
          err_d   = err_new;
          count_d = count_q + 3'd1;
          if (count_q == 3'd3) begin
            if (!err_new) begin
              state_d = StOpen;
              out_d   = 1'b1;
              fails_d = 3'd0;
            end else if (fails_q + 3'd1 == MaxTries) begin
              state_d  = StAlarm;
              buzzer_d = 1'b1;
            end else begin
              fails_d = fails_q + 3'd1;
              count_d = 3'd0;
              err_d   = 1'b0;
            end
          end
        end
      end
      StOpen: begin
        if (!bus.start) begin
          state_d = StIdle;
          out_d   = 1'b0;
          count_d = 3'd0;
        end
      end
      StAlarm: begin
        // Only reset leaves the alarm.
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= 3'd0;
      err_q    <= 1'b0;
      fails_q  <= 3'd0;
      ci_q     <= 4'h0;
      out_q    <= 1'b0;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      err_q    <= err_d;
      fails_q  <= fails_d;
      ci_q     <= ci_d;
      out_q    <= out_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.buzzer = buzzer_q;
  assign bus.count  = count_q;
  assign bus.cp     = cp;
  assign bus.ci     = ci_q;

endmodule

// File: tb/tb_code_lock.sv
module tb_code_lock;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  code_lock_if bus ();

  code_lock #(
    .CODE      (16'hABFD),
    .MAX_TRIES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter4(input logic [15:0] seq);
    for (int i = 0; i < 4; i++) begin
      bus.digit = seq[15 - 4 * i -: 4];
      step();
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.digit = 4'h0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.out !== 1'b0) begin
      errors++; $display("FAIL reset_out: got %b want 0", bus.out);
    end
    checks++;
    if (bus.buzzer !== 1'b0) begin
      errors++; $display("FAIL reset_buzzer: got %b want 0", bus.buzzer);
    end
    checks++;
    if (bus.count !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", bus.count);
    end
    checks++;
    if (bus.ci !== 4'h0) begin
      errors++; $display("FAIL reset_ci: got %h want 0", bus.ci);
    end
    checks++;
    if (bus.cp !== 4'hA) begin
      errors++; $display("FAIL reset_cp: got %h want a", bus.cp);
    end
  endtask

  task automatic test_unlock();
    logic [15:0] seq;
    seq = 16'hABFD;
    bus.start = 1'b1;
    step();
    checks++;
    if (bus.count !== 3'd0) begin
      errors++; $display("FAIL arm_count: got %0d want 0", bus.count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.cp !== seq[15 - 4 * i -: 4]) begin
        errors++; $display("FAIL unlock_cp%0d: got %h want %h", i, bus.cp, seq[15 - 4 * i -: 4]);
      end
      bus.digit = seq[15 - 4 * i -: 4];
      step();
      checks++;
      if (bus.count !== 3'(i + 1)) begin
        errors++; $display("FAIL unlock_count%0d: got %0d want %0d", i, bus.count, i + 1);
      end
      checks++;
      if (bus.ci !== seq[15 - 4 * i -: 4]) begin
        errors++; $display("FAIL unlock_ci%0d: got %h want %h", i, bus.ci, seq[15 - 4 * i -: 4]);
      end
      checks++;
      if (bus.out !== (i == 3)) begin
        errors++; $display("FAIL unlock_out%0d: got %b want %b", i, bus.out, (i == 3));
      end
    end
    checks++;
    if (bus.buzzer !== 1'b0) begin
      errors++; $display("FAIL unlock_buzzer: got %b want 0", bus.buzzer);
    end
    checks++;
    if (bus.cp !== 4'h0) begin
      errors++; $display("FAIL open_cp: got %h want 0", bus.cp);
    end
  endtask

  task automatic test_open_ignore();
    bus.digit = 4'hC;
    step();
    bus.digit = 4'h0;
    step();
    checks++;
    if (bus.out !== 1'b1) begin
      errors++; $display("FAIL open_hold_out: got %b want 1", bus.out);
    end
    checks++;
    if (bus.ci !== 4'hD) begin
      errors++; $display("FAIL open_hold_ci: got %h want d", bus.ci);
    end
    checks++;
    if (bus.count !== 3'd4) begin
      errors++; $display("FAIL open_hold_count: got %0d want 4", bus.count);
    end
    bus.start = 1'b0;
    step();
    checks++;
    if (bus.out !== 1'b0) begin
      errors++; $display("FAIL relock_out: got %b want 0", bus.out);
    end
    checks++;
    if (bus.count !== 3'd0) begin
      errors++; $display("FAIL relock_count: got %0d want 0", bus.count);
    end
    // In IDLE, digits must not be sampled.
    bus.digit = 4'h7;
    step();
    checks++;
    if (bus.ci !== 4'hD || bus.count !== 3'd0) begin
      errors++; $display("FAIL idle_ignore: got ci=%h count=%0d want ci=d count=0", bus.ci, bus.count);
    end
  endtask

  task automatic test_alarm();
    logic [15:0] bad [3];
    bad[0] = 16'hAFB1;
    bad[1] = 16'hDAD2;
    bad[2] = 16'hFAE3;
    do_reset();
    bus.start = 1'b1;
    step();
    for (int a = 0; a < 3; a++) begin
      enter4(bad[a]);
      checks++;
      if (bus.out !== 1'b0) begin
        errors++; $display("FAIL alarm_out%0d: got %b want 0", a, bus.out);
      end
      checks++;
      if (bus.buzzer !== (a == 2)) begin
        errors++; $display("FAIL alarm_buzzer%0d: got %b want %b", a, bus.buzzer, (a == 2));
      end
      if (a < 2) begin
        checks++;
        if (bus.count !== 3'd0) begin
          errors++; $display("FAIL alarm_count%0d: got %0d want 0", a, bus.count);
        end
      end
    end
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    enter4(16'hABFD);
    checks++;
    if (bus.buzzer !== 1'b1 || bus.out !== 1'b0) begin
      errors++; $display("FAIL alarm_sticky: got buzzer=%b out=%b want 1 0", bus.buzzer, bus.out);
    end
    checks++;
    if (bus.ci !== 4'h3) begin
      errors++; $display("FAIL alarm_ci_hold: got %h want 3", bus.ci);
    end
    do_reset();
    checks++;
    if (bus.buzzer !== 1'b0) begin
      errors++; $display("FAIL alarm_clear: got %b want 0", bus.buzzer);
    end
  endtask

  task automatic test_first_mismatch();
    do_reset();
    bus.start = 1'b1;
    step();
    enter4(16'h0BFD);
    checks++;
    if (bus.out !== 1'b0 || bus.count !== 3'd0) begin
      errors++; $display("FAIL first_mm: got out=%b count=%0d want 0 0", bus.out, bus.count);
    end
    enter4(16'hABFD);
    checks++;
    if (bus.out !== 1'b1) begin
      errors++; $display("FAIL first_mm_retry: got %b want 1", bus.out);
    end
    // Success clears the fail count: two further failures must not alarm.
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    enter4(16'h1111);
    enter4(16'h2222);
    checks++;
    if (bus.buzzer !== 1'b0) begin
      errors++; $display("FAIL fails_cleared: got %b want 0", bus.buzzer);
    end
    enter4(16'h3333);
    checks++;
    if (bus.buzzer !== 1'b1) begin
      errors++; $display("FAIL third_fail_alarm: got %b want 1", bus.buzzer);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.start = 1'b1;
    step();
    bus.digit = 4'hA;
    step();
    bus.digit = 4'hB;
    step();
    checks++;
    if (bus.count !== 3'd2) begin
      errors++; $display("FAIL mid_count: got %0d want 2", bus.count);
    end
    // Reset asserted together with start=1: reset wins.
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bus.count !== 3'd0 || bus.ci !== 4'h0 || bus.out !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got count=%0d ci=%h out=%b want 0 0 0",
                         bus.count, bus.ci, bus.out);
    end
    step();
    enter4(16'hABFD);
    checks++;
    if (bus.out !== 1'b1) begin
      errors++; $display("FAIL mid_reunlock: got %b want 1", bus.out);
    end
  endtask

  task automatic test_abort();
    do_reset();
    bus.start = 1'b1;
    step();
    enter4(16'h1234);
    enter4(16'h5678);
    bus.digit = 4'hA;
    step();
    bus.digit = 4'hB;
    step();
    bus.digit = 4'hF;
    step();
    // start=0 together with a wrong 4th symbol: discarded, not a failure.
    bus.start = 1'b0;
    bus.digit = 4'h1;
    step();
    checks++;
    if (bus.count !== 3'd0 || bus.buzzer !== 1'b0 || bus.out !== 1'b0) begin
      errors++; $display("FAIL abort: got count=%0d buzzer=%b out=%b want 0 0 0",
                         bus.count, bus.buzzer, bus.out);
    end
    checks++;
    if (bus.ci !== 4'hF) begin
      errors++; $display("FAIL abort_ci: got %h want f", bus.ci);
    end
    bus.start = 1'b1;
    step();
    enter4(16'hABFD);
    checks++;
    if (bus.out !== 1'b1 || bus.buzzer !== 1'b0) begin
      errors++; $display("FAIL abort_reunlock: got out=%b buzzer=%b want 1 0", bus.out, bus.buzzer);
    end
  endtask

  task automatic test_back_to_back();
    // Repeated identical symbols each count as separate entries.
    do_reset();
    bus.start = 1'b1;
    step();
    enter4(16'hAAAA);
    checks++;
    if (bus.count !== 3'd0 || bus.out !== 1'b0) begin
      errors++; $display("FAIL repeat_sym: got count=%0d out=%b want 0 0", bus.count, bus.out);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.digit = 4'h0;
    test_reset();
    test_unlock();
    test_open_ignore();
    test_alarm();
    test_first_mismatch();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
